// File: rtl/neuron_seq_ctrl.sv
// Single-neuron evaluator: bias plus NUM multiply-accumulate terms on one shared
// multiplier, then one cycle to capture the external tanh unit's result.
//
// state | meaning
// IDLE  | waiting for i_start
// MAC   | accumulating k[idx]*w[idx], one term per cycle
// ACT   | o_sum is final; capture i_act into o_a
// DONE  | o_done pulse; a new start may be accepted here
module neuron_seq_ctrl #(
  parameter int NUM   = 3,
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic signed [NUM*WIDTH-1:0] i_k,
  input  logic signed [NUM*WIDTH-1:0] i_w,
  input  logic signed [WIDTH-1:0]     i_b,
  output logic signed [WIDTH-1:0]     o_sum,
  input  logic signed [WIDTH-1:0]     i_act,
  output logic signed [WIDTH-1:0]     o_a,
  output logic [7:0]                  o_idx,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int ACCW  = 2*WIDTH + 8;
  localparam int PRODW = 2*WIDTH;
  localparam logic [7:0] LAST = 8'(NUM - 1);

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

  state_t state, state_nxt;
  logic load, mac_en, act_en;

  logic [NUM*WIDTH-1:0]    k_reg, w_reg;
  logic signed [ACCW-1:0]  acc, acc_sh, b_ext, prod_ext;
  logic [7:0]              idx;
  logic signed [WIDTH-1:0] k_sel, w_sel;
  logic signed [PRODW-1:0] prod;
  logic [ACCW-WIDTH:0]     top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mac_en    = 1'b0;
    act_en    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_idx     = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        o_busy = 1'b1;
        mac_en = 1'b1;
        o_idx  = idx;
        if (idx == LAST) state_nxt = ACT;
      end
      ACT: begin
        o_busy    = 1'b1;
        act_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          load      = 1'b1;
          state_nxt = MAC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiplier: operand pair selected by idx.
  always_comb begin
    k_sel = '0;
    w_sel = '0;
    for (int j = 0; j < NUM; j++) begin
      if (idx == 8'(j)) begin
        k_sel = k_reg[j*WIDTH +: WIDTH];
        w_sel = w_reg[j*WIDTH +: WIDTH];
      end
    end
  end

  assign prod     = PRODW'(k_sel) * PRODW'(w_sel);
  assign prod_ext = {{(ACCW-PRODW){prod[PRODW-1]}}, prod};
  // Bias moved up to the product's binary point so the sum stays full precision.
  assign b_ext    = {{(ACCW-WIDTH){i_b[WIDTH-1]}}, i_b} << FRAC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg <= '0;
      w_reg <= '0;
      acc   <= '0;
      idx   <= '0;
      o_a   <= '0;
    end else begin
      if (load) begin
        k_reg <= i_k;
        w_reg <= i_w;
        acc   <= b_ext;
        idx   <= '0;
      end else if (mac_en) begin
        acc <= acc + prod_ext;
        idx <= idx + 8'd1;
      end
      if (act_en) o_a <= i_act;
    end
  end

  // Value fits in WIDTH bits when every bit from WIDTH-1 upward matches the sign.
  assign acc_sh = acc >>> FRAC;
  assign top    = acc_sh[ACCW-1:WIDTH-1];

  always_comb begin
    if ((&top) || ~(|top)) o_sum = acc_sh[WIDTH-1:0];
    else if (acc_sh[ACCW-1]) o_sum = {1'b1, {(WIDTH-1){1'b0}}};
    else o_sum = {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Bench for neuron_seq_ctrl: transaction-level model checked every cycle plus
// directed cases with literal expected values.
module tb_neuron_seq_ctrl;
  localparam int NUM   = 3;
  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam logic signed [95:0] SAT_HI = 96'sd2147483647;
  localparam logic signed [95:0] SAT_LO = -96'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic signed [NUM*WIDTH-1:0] i_k = '0;
  logic signed [NUM*WIDTH-1:0] i_w = '0;
  logic signed [WIDTH-1:0] i_b = '0;
  logic signed [WIDTH-1:0] o_sum, i_act, o_a;
  logic [7:0] o_idx;
  logic o_busy, o_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_seq_ctrl #(.NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k(i_k), .i_w(i_w), .i_b(i_b),
    .o_sum(o_sum), .i_act(i_act), .o_a(o_a), .o_idx(o_idx),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Pre-activation in real-number terms: b + sum(k*w), floored to Q8.24, clamped.
  function automatic logic signed [31:0] model_sum(input logic [95:0] k, input logic [95:0] w,
                                                   input logic signed [31:0] b);
    logic signed [95:0] s;
    logic signed [31:0] kk, ww;
    s = 96'(b) * 96'sd16777216;
    for (int j = 0; j < 3; j++) begin
      kk = k[j*32 +: 32];
      ww = w[j*32 +: 32];
      s = s + 96'(kk) * 96'(ww);
    end
    s = s >>> 24;
    if (s > SAT_HI) return 32'sh7FFFFFFF;
    if (s < SAT_LO) return 32'sh80000000;
    return s[31:0];
  endfunction

  // External tanh unit stand-in: x - x|x|/4 inside (-2,2), +/-1.0 outside.
  function automatic logic signed [31:0] tanh_unit(input logic signed [31:0] x);
    longint xl, ax;
    xl = longint'(x);
    ax = (xl < 0) ? -xl : xl;
    if (ax >= 64'sd33554432) return (xl < 0) ? 32'shFF000000 : 32'sh01000000;
    return 32'(xl - ((xl * ax) >>> 26));
  endfunction

  assign i_act = tanh_unit(o_sum);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Model: m_pos counts edges since the accepted start (0 = no evaluation).
  int m_pos;
  logic signed [31:0] m_pend, m_sum, m_a;
  logic m_sum_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos    <= 0;
      m_a      <= '0;
      m_sum    <= '0;
      m_pend   <= '0;
      m_sum_ok <= 1'b1;
    end else if ((m_pos == 0 || m_pos == NUM+2) && i_start) begin
      m_pos    <= 1;
      m_pend   <= model_sum(i_k, i_w, i_b);
      m_sum_ok <= 1'b0;
    end else if (m_pos == NUM+2) begin
      m_pos <= 0;
    end else if (m_pos > 0) begin
      m_pos <= m_pos + 1;
      if (m_pos == NUM) begin
        m_sum    <= m_pend;
        m_sum_ok <= 1'b1;
      end
      if (m_pos == NUM+1) m_a <= tanh_unit(m_pend);
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(o_busy), 32'(m_pos >= 1 && m_pos <= NUM+1));
    check("done", 32'(o_done), 32'(m_pos == NUM+2));
    check("idx", 32'(o_idx), (m_pos >= 1 && m_pos <= NUM) ? 32'(m_pos - 1) : 32'd0);
    check("o_a", o_a, m_a);
    if (m_sum_ok) check("o_sum", o_sum, m_sum);
  end

  task automatic run_case(input logic [95:0] k, input logic [95:0] w, input logic [31:0] b,
                          output int lat, output int busy_n);
    @(negedge clk);
    i_k = k; i_w = w; i_b = b; i_start = 1'b1;
    lat = 0; busy_n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) i_start = 1'b0;
      if (c == 2) begin
        i_k = {$urandom, $urandom, $urandom};
        i_w = {$urandom, $urandom, $urandom};
        i_b = $urandom;
      end
      if (o_busy) busy_n++;
      if (o_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_done) begin
        lat = c;
        break;
      end
    end
  endtask

  localparam logic [95:0] K1 = {32'h01000000, 32'h01000000, 32'h01000000};
  localparam logic [95:0] W1 = {32'h00400000, 32'h00400000, 32'h00800000};
  localparam logic [95:0] K2 = {3{32'hFF000000}};
  localparam logic [95:0] W2 = {3{32'h01000000}};
  localparam logic [95:0] KS = {3{32'h7FFFFFFF}};
  localparam logic [95:0] KN = {3{32'h80000000}};
  localparam logic [95:0] K5 = {32'h00001234, 32'hFF400000, 32'h02800000};
  localparam logic [95:0] W5 = {32'hFFFFF000, 32'h01800000, 32'h00300000};

  initial begin
    int lat, busy_n, seen;
    repeat (2) @(negedge clk);
    check("rst_sum", o_sum, 32'h0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;

    run_case(K1, W1, 32'h0, lat, busy_n);
    check("c1_latency", 32'(lat), 32'd5);
    check("c1_busy_cycles", 32'(busy_n), 32'd4);
    check("c1_sum", o_sum, 32'h01000000);
    check("c1_act", o_a, 32'h00C00000);

    run_case(K2, W2, 32'hFF800000, lat, busy_n);
    check("c2_latency", 32'(lat), 32'd5);
    check("c2_sum", o_sum, 32'hFC800000);
    check("c2_act", o_a, 32'hFF000000);

    run_case(KS, KS, 32'h7FFFFFFF, lat, busy_n);
    check("sat_pos_sum", o_sum, 32'h7FFFFFFF);
    check("sat_pos_act", o_a, 32'h01000000);

    run_case(KN, KS, 32'h0, lat, busy_n);
    check("sat_neg_sum", o_sum, 32'h80000000);

    run_case(K5, W5, 32'h00200000, lat, busy_n);
    check("mix_latency", 32'(lat), 32'd5);

    // Start held high: accepted only in DONE; new operands applied in DONE.
    @(negedge clk);
    i_k = K1; i_w = W1; i_b = 32'h0; i_start = 1'b1;
    wait_done(lat);
    check("hs_first_latency", 32'(lat), 32'd5);
    check("hs_first_sum", o_sum, 32'h01000000);
    i_k = K2; i_w = W2; i_b = 32'hFF800000;
    wait_done(lat);
    check("hs_period", 32'(lat), 32'd5);
    check("hs_second_sum", o_sum, 32'hFC800000);
    i_start = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-MAC.
    @(negedge clk);
    i_k = K1; i_w = W1; i_b = 32'h0; i_start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_idx == 8'd1) begin
        seen = 1;
        break;
      end
    end
    check("abort_reached_idx1", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_a", o_a, 32'h0);
    check("abort_sum", o_sum, 32'h0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_idx", 32'(o_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_case(K2, W2, 32'hFF800000, lat, busy_n);
    check("post_abort_latency", 32'(lat), 32'd5);
    check("post_abort_sum", o_sum, 32'hFC800000);
    check("post_abort_act", o_a, 32'hFF000000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/neuron_seq_ctrl.md
NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM, default 3: number of input/weight pairs per neuron.
REQ-002 The block SHALL have parameter WIDTH, default 32: signed fixed-point word width.
REQ-003 The block SHALL have parameter FRAC, default 24: fractional bits (Q8.24 at default; 1.0 = 0x01000000).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_start, input, 1 bit: request one neuron evaluation.
REQ-007 The block SHALL have port i_k, input, NUM*WIDTH bits, signed: inputs; element j is in bits [j*WIDTH +: WIDTH].
REQ-008 The block SHALL have port i_w, input, NUM*WIDTH bits, signed: weights, packed the same way as i_k.
REQ-009 The block SHALL have port i_b, input, WIDTH bits, signed: bias.
REQ-010 The block SHALL have port o_sum, output, WIDTH bits, signed: saturated pre-activation, which drives the external tanh unit.
REQ-011 The block SHALL have port i_act, input, WIDTH bits, signed: combinational tanh(o_sum) returned by the external unit.
REQ-012 The block SHALL have port o_a, output, WIDTH bits, signed: registered activation result.
REQ-013 The block SHALL have port o_idx, output, 8 bits: index of the pair being accumulated.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high in states MAC and ACT.
REQ-015 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when o_a is updated.

Function
REQ-016 The FSM SHALL have states IDLE, MAC, ACT and DONE, and SHALL use one shared multiplier, time-multiplexed over the NUM pairs.
REQ-017 In IDLE or DONE, with i_start high at a rising edge: latch i_k, i_w, i_b into operand registers; set acc to sign-extended i_b << FRAC (full-precision alignment); set idx to 0; go to MAC.
REQ-018 In IDLE with i_start low: stay in IDLE. In DONE with i_start low: go to IDLE.
REQ-019 In MAC, each cycle: acc <= acc + k[idx]*w[idx] as a full 2*WIDTH signed product; idx <= idx+1; after the idx = NUM-1 term, go to ACT.
REQ-020 The accumulator SHALL be 2*WIDTH+8 bits signed, so that no intermediate overflow occurs for NUM <= 256.
REQ-021 o_sum SHALL be acc arithmetically shifted right by FRAC, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; o_sum is driven from registers only.
REQ-022 In ACT, exactly one cycle: o_a <= i_act; go to DONE.
REQ-023 In DONE: o_done = 1 for that single cycle; o_a is held until the next ACT.
REQ-024 Latency: when i_start is sampled at edge E, o_done SHALL be high in the cycle after edge E+NUM+1; throughput is one result per NUM+2 cycles back-to-back.
REQ-025 An i_start sampled in MAC or ACT SHALL be ignored, with no queuing and no corruption of the operands.
REQ-026 Changes on i_k, i_w or i_b after the start edge SHALL NOT affect the current result.
REQ-027 o_idx SHALL equal idx in MAC and 0 in all other states.
REQ-028 o_sum SHALL remain stable from entry into ACT until the next start is accepted.

Reset
REQ-029 While rst is high, independent of clk: state = IDLE; acc, idx, operands, o_a = 0; o_busy = 0; o_done = 0; o_sum = 0; o_idx = 0.
REQ-030 rst asserted mid-MAC or mid-ACT SHALL abort the evaluation; o_done SHALL NOT pulse for that evaluation, and o_a SHALL read 0.
REQ-031 After rst deasserts, the first i_start SHALL be accepted normally.

Verification
REQ-032 Reset check: assert rst mid-cycle -> all outputs are 0 immediately, with no clock edge needed.
REQ-033 Directed case, NUM=3: k=(1.0,1.0,1.0), w=(0.5,0.25,0.25), b=0 -> o_sum=0x01000000; o_a equals the bench tanh model output; o_done pulses exactly 5 cycles after the start edge; o_busy is high for 4 cycles.
REQ-034 Negative case: k=(-1.0,-1.0,-1.0), w=(1.0,1.0,1.0), b=-0.5 -> o_sum=0xFC800000 (-3.5).
REQ-035 Saturation case: all k and w = 0x7FFFFFFF, b=0x7FFFFFFF -> o_sum=0x7FFFFFFF; all k = 0x80000000, all w = 0x7FFFFFFF -> o_sum=0x80000000.
REQ-036 Handshake case: i_start held high continuously -> a new start is accepted only in DONE (one per 5 cycles); starts during MAC/ACT are ignored; a new operand set applied in DONE yields its own correct result.
REQ-037 Abort case: rst pulsed when o_idx=1 -> no o_done pulse, o_a = 0; the next start produces the correct result.
